divider_iter: RTL and testbench
===============================

Name: divider_iter

Overview:
- Iterative restoring integer divider for the CPU execute path; sits directly downstream of operand selection and drives the team's addsub block in subtract mode once per iteration.
- Accepts one divide request per start pulse and produces quotient and remainder after a fixed latency.
- Signed results follow RISC-V DIV/DIVU/REM/REMU semantics.

Parameters:
- WIDTH, 32, operand and result width in bits.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- is_signed  input  1  1 = signed divide, 0 = unsigned; captured with start.
- dividend  input  WIDTH  numerator; captured with start.
- divisor  input  WIDTH  denominator; captured with start.
- busy  output  1  high while a divide is in progress.
- done  output  1  one-cycle pulse; results valid from this cycle.
- quotient  output  WIDTH  result quotient.
- remainder  output  WIDTH  result remainder.
- div_by_zero  output  1  set with done when the captured divisor was 0.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy, done, div_by_zero, quotient and remainder are all 0; internal registers are cleared. Reset mid-divide abandons the operation and produces no done.
- States: IDLE -> PREP -> RUN -> FIX -> IDLE.
- IDLE: start=1 at a rising edge captures the operands and is_signed, sets busy=1 and moves to PREP. start=0 stays in IDLE.
- PREP (1 cycle):
  - Record the quotient sign as dividend_msb XOR divisor_msb, and the remainder sign as dividend_msb. Both are recorded only when signed.
  - Replace each operand by its magnitude (two's-complement negate if signed and negative). The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) as unsigned.
  - Clear the partial remainder and load the iteration counter with WIDTH-1.
- RUN (exactly WIDTH cycles), per cycle:
  - Shift {partial remainder, quotient register} left by 1, bringing in the next dividend bit MSB-first.
  - Compute trial = shifted remainder - divisor in WIDTH+1 bits (subtract via addsub, is_sub=1).
  - If trial is non-negative, the remainder becomes trial and quotient bit 1 is shifted in. Otherwise the remainder is kept and 0 is shifted in.
  - The counter decrements. Leave RUN after the iteration with counter=0.
- FIX (1 cycle):
  - If the divisor was 0: quotient = all ones, remainder = original dividend (unmodified), div_by_zero = 1.
  - Otherwise: negate the quotient if the quotient sign is set, and negate the remainder if the remainder sign is set; div_by_zero = 0.
  - Overflow (signed -2^(WIDTH-1) / -1) falls out naturally: quotient = -2^(WIDTH-1), remainder = 0.
  - On leaving FIX: done=1 for exactly one cycle, busy=0, and the outputs are updated.
- Latency: start sampled at edge N; done is high and results are valid after edge N+WIDTH+2. busy is high after edges N+1 through N+WIDTH+1.
- quotient, remainder and div_by_zero hold until the next done. They do not change during a subsequent divide.
- start while busy=1 is ignored; there is no queueing.
- start asserted in the same cycle done is high is accepted (the state is already IDLE), giving back-to-back throughput of one divide per WIDTH+2 cycles.
- Quotient truncates toward zero; the remainder takes the sign of the dividend.

Test Plan:
- Unsigned 100 / 7, start at edge 0 -> done high exactly after edge 34; quotient=14, remainder=2, div_by_zero=0; busy high for edges 1-33.
- Signed -100 / 7, then 100 / -7 -> q=-14, r=-2 (0xFFFFFFF2, 0xFFFFFFFE); then q=-14, r=2.
- Unsigned 1234 / 0, and signed -5 / 0 -> q=0xFFFFFFFF, r=1234, div_by_zero=1; then q=0xFFFFFFFF, r=0xFFFFFFFB, div_by_zero=1.
- Signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0; unsigned 0xFFFFFFFF / 1 -> q=0xFFFFFFFF, r=0.
- Start 50/5, pulse start with 9/3 at edge 10 -> second request ignored; done once with q=10, r=0; then start 9/3 in the done cycle -> accepted, q=3 after a further 34 edges.
- Start 1000/3, assert RST asynchronously mid-cycle at edge 15 for 2 cycles -> all outputs 0 immediately, no done pulse. After release, 1000/3 completes with q=333, r=1.

Source files
------------

// File: rtl/divider_iter.sv
// Iterative restoring divider: one quotient bit per cycle, RISC-V DIV/DIVU/REM/REMU results.
// Flow is IDLE -> PREP (sign strip) -> RUN (WIDTH iterations) -> FIX (sign restore / divide-by-zero).
module divider_iter #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

  state_t           state_q, state_d;
  logic             sgn_q, sgn_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_by_zero_q, div_by_zero_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  always_comb begin
    state_d       = state_q;
    sgn_d         = sgn_q;
    q_neg_d       = q_neg_q;
    r_neg_d       = r_neg_q;
    a_d           = a_q;
    b_d           = b_q;
    rem_d         = rem_q;
    dvd_d         = dvd_q;
    cnt_d         = cnt_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    // a_q doubles as the dividend shift-out and the quotient shift-in register
    shifted       = {rem_q, a_q[WIDTH-1]};
    trial         = shifted - {1'b0, b_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = dividend;
          b_d     = divisor;
          dvd_d   = dividend;
          sgn_d   = is_signed;
          busy_d  = 1'b1;
          state_d = PREP;
        end
      end
      PREP: begin
        q_neg_d = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        r_neg_d = sgn_q & a_q[WIDTH-1];
        if (sgn_q && a_q[WIDTH-1]) a_d = -a_q;
        if (sgn_q && b_q[WIDTH-1]) b_d = -b_q;
        rem_d   = '0;
        cnt_d   = CW'(WIDTH - 1);
        state_d = RUN;
      end
      RUN: begin
        a_d   = {a_q[WIDTH-2:0], ~trial[WIDTH]};
        rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        // A zero divisor is still zero after the sign strip, so b_q identifies it
        if (b_q == '0) begin
          quotient_d    = '1;
          remainder_d   = dvd_q;
          div_by_zero_d = 1'b1;
        end else begin
          quotient_d    = q_neg_q ? -a_q : a_q;
          remainder_d   = r_neg_q ? -rem_q : rem_q;
          div_by_zero_d = 1'b0;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      sgn_q         <= 1'b0;
      q_neg_q       <= 1'b0;
      r_neg_q       <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      rem_q         <= '0;
      dvd_q         <= '0;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sgn_q         <= sgn_d;
      q_neg_q       <= q_neg_d;
      r_neg_q       <= r_neg_d;
      a_q           <= a_d;
      b_q           <= b_d;
      rem_q         <= rem_d;
      dvd_q         <= dvd_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_divider_iter.sv
// Bench for divider_iter: arithmetic reference model with a per-cycle compare process,
// plus directed vectors whose results are pinned by hand-computed literals.
module tb_divider_iter;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           due;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int   n_compares = 0;
  int   n_miscompares = 0;
  int   cyc = 0;
  exp_t pending[$];
  exp_t held;

  divider_iter #(.WIDTH(W)) dut (
    .CLK(CLK),
    .RST(RST),
    .start(start),
    .is_signed(is_signed),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Reference result straight from RISC-V division rules using wide signed arithmetic
  function automatic exp_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa;
    longint sb;
    e.due = 0;
    if (b == '0) begin
      e.q   = '1;
      e.r   = a;
      e.dbz = 1'b1;
    end else if (s) begin
      sa    = longint'($signed(a));
      sb    = longint'($signed(b));
      e.q   = W'(sa / sb);
      e.r   = W'(sa % sb);
      e.dbz = 1'b0;
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_compares++;
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle compare: done timing, busy window and result hold behaviour
  always @(negedge CLK) begin
    if (!RST) begin
      logic exp_done;
      exp_done = (pending.size() > 0) && (pending[0].due == cyc);
      checkOutput("done", W'(done), W'(exp_done));
      if (exp_done) held = pending.pop_front();
      checkOutput("quotient", quotient, held.q);
      checkOutput("remainder", remainder, held.r);
      checkOutput("div_by_zero", W'(div_by_zero), W'(held.dbz));
      if (pending.size() == 0) begin
        checkOutput("busy_idle", W'(busy), 32'd0);
      end else if (cyc >= pending[0].due - (W + 1) && cyc <= pending[0].due - 1) begin
        checkOutput("busy_active", W'(busy), 32'd1);
      end
    end
  end

  // Caller sits just after a negedge; start is presented for exactly one rising edge
  task automatic applyStimulus(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    #1;
    start     = 1'b1;
    is_signed = s;
    dividend  = a;
    divisor   = b;
    if (pending.size() == 0) begin
      e     = model(s, a, b);
      e.due = cyc + 1 + W + 2;
      pending.push_back(e);
    end
    @(negedge CLK);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      @(negedge CLK);
      if (done) break;
    end
    if (i == limit) begin
      n_compares++;
      n_miscompares++;
      $display("[TB] FAIL done_timeout: got no done in %0d cycles, expected a done pulse", limit);
    end
  endtask

  task automatic runVector(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz);
    applyStimulus(s, a, b);
    waitDone(W + 8);
    checkOutput("lit_quotient", quotient, eq);
    checkOutput("lit_remainder", remainder, er);
    checkOutput("lit_div_by_zero", W'(div_by_zero), W'(edbz));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, W'(busy), 32'd0);
    checkOutput({tag, "_done"}, W'(done), 32'd0);
    checkOutput({tag, "_quotient"}, quotient, 32'd0);
    checkOutput({tag, "_remainder"}, remainder, 32'd0);
    checkOutput({tag, "_div_by_zero"}, W'(div_by_zero), 32'd0);
  endtask

  initial begin
    held = '{q: '0, r: '0, dbz: 1'b0, due: 0};
    #12;
    checkAllZero("reset");
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    runVector(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    runVector(1'b1, -32'sd100, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
    runVector(1'b1, 32'd100, -32'sd7, 32'hFFFFFFF2, 32'd2, 1'b0);
    runVector(1'b0, 32'd1234, 32'd0, 32'hFFFFFFFF, 32'd1234, 1'b1);
    runVector(1'b1, -32'sd5, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1);
    runVector(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0);
    runVector(1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0);
    runVector(1'b1, -32'sd7, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    runVector(1'b1, 32'd7, -32'sd2, 32'hFFFFFFFD, 32'd1, 1'b0);
    runVector(1'b0, 32'd5, 32'd9, 32'd0, 32'd5, 1'b0);
    runVector(1'b0, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0);
    runVector(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0);

    // Second request while busy must be dropped, then one in the done cycle accepted
    applyStimulus(1'b0, 32'd50, 32'd5);
    repeat (9) @(negedge CLK);
    applyStimulus(1'b0, 32'd9, 32'd3);
    waitDone(W + 8);
    checkOutput("busy_drop_quotient", quotient, 32'd10);
    checkOutput("busy_drop_remainder", remainder, 32'd0);
    runVector(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

    // Asynchronous reset mid-divide abandons the operation
    applyStimulus(1'b0, 32'd1000, 32'd3);
    repeat (13) @(negedge CLK);
    @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    checkAllZero("midreset");
    pending.delete();
    held = '{q: '0, r: '0, dbz: 1'b0, due: 0};
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    runVector(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);

    repeat (4) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_compares, n_miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish, expected completion");
    $fatal(1);
  end

endmodule
